// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit.
//   - op encodings for the 3-bit op field driven by the decoder
//   - FSM state type used by md_unit
//   - small helper to size the latency counter
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic int max_lat(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_arith.sv
// md_arith: purely combinational result generator for md_unit.
// Ports:
//   op       in  3      operation code (md_pkg encodings)
//   a        in  WIDTH  rs operand
//   b        in  WIDTH  rt operand
//   res_hi   out WIDTH  value destined for HI
//   res_lo   out WIDTH  value destined for LO
//   div_zero out 1      DIV/DIVU with b == 0 (result must not be committed)
// Non-md ops (MTHI/MTLO/undefined) produce zero results.
module md_arith
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic                      b_zero;
  logic                      sdiv_ovf;
  logic        [WIDTH-1:0]   b_div_s;
  logic        [WIDTH-1:0]   b_div_u;
  logic signed [WIDTH-1:0]   quot_s;
  logic signed [WIDTH-1:0]   rem_s;
  logic        [WIDTH-1:0]   quot_u;
  logic        [WIDTH-1:0]   rem_u;

  // Operands are extended to full product width so both halves are exact.
  assign prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign b_zero   = (b == '0);
  assign sdiv_ovf = (a == MOST_NEG) && (b == '1);

  // Divisors are replaced by 1 in the cases that get special-cased below,
  // so the dividers never see zero or the overflowing signed pair.
  assign b_div_s = (b_zero || sdiv_ovf) ? ONE : b;
  assign b_div_u = b_zero ? ONE : b;

  // Signed / and % truncate toward zero; remainder takes the dividend sign.
  assign quot_s = $signed(a) / $signed(b_div_s);
  assign rem_s  = $signed(a) % $signed(b_div_s);
  assign quot_u = a / b_div_u;
  assign rem_u  = a % b_div_u;

  always_comb begin
    res_hi   = '0;
    res_lo   = '0;
    div_zero = 1'b0;
    case (op)
      MD_MULT: begin
        res_hi = prod_s[2*WIDTH-1:WIDTH];
        res_lo = prod_s[WIDTH-1:0];
      end
      MD_MULTU: begin
        res_hi = prod_u[2*WIDTH-1:WIDTH];
        res_lo = prod_u[WIDTH-1:0];
      end
      MD_DIV: begin
        div_zero = b_zero;
        if (sdiv_ovf) begin
          res_hi = '0;
          res_lo = MOST_NEG;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      MD_DIVU: begin
        div_zero = b_zero;
        res_hi   = rem_u;
        res_lo   = quot_u;
      end
      default: begin
        res_hi   = '0;
        res_lo   = '0;
        div_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers.
// The result is computed combinationally when the op is accepted, parked in
// pending registers, and committed to HI/LO after MULT_LAT / DIV_LAT cycles
// so the pipeline sees the latency of a real iterative unit.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous active-high reset
//   start  in  1      md instruction valid in E stage (one cycle)
//   op     in  3      operation code (md_pkg encodings)
//   a      in  WIDTH  rs operand
//   b      in  WIDTH  rt operand
//   busy   out 1      registered: multi-cycle operation in progress
//   hi     out WIDTH  HI register
//   lo     out WIDTH  LO register
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(max_lat(MULT_LAT, DIV_LAT) + 1);

  md_state_e        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] pend_hi_reg;
  logic [WIDTH-1:0] pend_lo_reg;
  logic             pend_skip_reg;   // divide by zero: run the latency, commit nothing
  logic             busy_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             div_zero;

  md_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .op       (op),
    .a        (a),
    .b        (b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      pend_hi_reg   <= '0;
      pend_lo_reg   <= '0;
      pend_skip_reg <= 1'b0;
      busy_reg      <= 1'b0;
      hi_reg        <= '0;
      lo_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU: begin
                pend_hi_reg   <= res_hi;
                pend_lo_reg   <= res_lo;
                pend_skip_reg <= 1'b0;
                cnt_reg       <= CNT_W'(MULT_LAT);
                busy_reg      <= 1'b1;
                state_reg     <= RUN;
              end
              MD_DIV, MD_DIVU: begin
                pend_hi_reg   <= res_hi;
                pend_lo_reg   <= res_lo;
                pend_skip_reg <= div_zero;
                cnt_reg       <= CNT_W'(DIV_LAT);
                busy_reg      <= 1'b1;
                state_reg     <= RUN;
              end
              MD_MTHI: hi_reg <= a;
              MD_MTLO: lo_reg <= a;
              default: ;  // undefined op: no-op
            endcase
          end
        end
        RUN: begin
          // Starts are ignored here; the hazard unit stalls on start||busy.
          if (cnt_reg == CNT_W'(1)) begin
            if (!pend_skip_reg) begin
              hi_reg <= pend_hi_reg;
              lo_reg <= pend_lo_reg;
            end
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit: a default instance (5/10 latency) and a
// short-latency instance (1/3) sharing clock and reset.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start0 = 1'b0;
  logic [2:0]  op0 = 3'd0;
  logic [31:0] a0 = '0;
  logic [31:0] b0 = '0;
  logic        busy0;
  logic [31:0] hi0, lo0;

  logic        start1 = 1'b0;
  logic [2:0]  op1 = 3'd0;
  logic [31:0] a1 = '0;
  logic [31:0] b1 = '0;
  logic        busy1;
  logic [31:0] hi1, lo1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
    .busy(busy0), .hi(hi0), .lo(lo0)
  );

  md_unit #(.WIDTH(32), .MULT_LAT(1), .DIV_LAT(3)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op on instance sel, then count the cycles busy stays high.
  // Returns with the bench in the first cycle after busy falls.
  task automatic run_op(input int sel, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int busy_cycles);
    int n;
    if (sel == 0) begin start0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else          begin start1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    n = 0;
    while (((sel == 0) ? busy0 : busy1) && n < 100) begin
      n++;
      tick();
    end
    busy_cycles = n;
    $display("txn dut%0d op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", sel, op, a, b, n,
             (sel == 0) ? hi0 : hi1, (sel == 0) ? lo0 : lo1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    n_checks++; if (hi0 !== 32'h0) begin n_fail++; $display("FAIL reset_hi got=%h exp=00000000", hi0); end
    n_checks++; if (lo0 !== 32'h0) begin n_fail++; $display("FAIL reset_lo got=%h exp=00000000", lo0); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got=%b exp=0", busy1); end
  endtask

  task automatic test_mult();
    int bc;
    run_op(0, MD_MULT, 32'hFFFFFFFD, 32'd5, bc);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL mult_busy got=%0d exp=5", bc); end
    n_checks++; if (hi0 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi got=%h exp=ffffffff", hi0); end
    n_checks++; if (lo0 !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo got=%h exp=fffffff1", lo0); end
    run_op(0, MD_MULTU, 32'hFFFFFFFD, 32'd5, bc);
    n_checks++; if (bc !== 5) begin n_fail++; $display("FAIL multu_busy got=%0d exp=5", bc); end
    n_checks++; if (hi0 !== 32'h00000004) begin n_fail++; $display("FAIL multu_hi got=%h exp=00000004", hi0); end
    n_checks++; if (lo0 !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL multu_lo got=%h exp=fffffff1", lo0); end
  endtask

  task automatic test_div();
    int bc;
    run_op(0, MD_DIV, 32'hFFFFFFF9, 32'd2, bc);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL div_busy got=%0d exp=10", bc); end
    n_checks++; if (lo0 !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo got=%h exp=fffffffd", lo0); end
    n_checks++; if (hi0 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi got=%h exp=ffffffff", hi0); end
    run_op(0, MD_DIVU, 32'd7, 32'd2, bc);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL divu_busy got=%0d exp=10", bc); end
    n_checks++; if (lo0 !== 32'd3) begin n_fail++; $display("FAIL divu_lo got=%h exp=00000003", lo0); end
    n_checks++; if (hi0 !== 32'd1) begin n_fail++; $display("FAIL divu_hi got=%h exp=00000001", hi0); end
  endtask

  task automatic test_mt_divzero();
    int bc;
    start0 = 1'b1; op0 = MD_MTLO; a0 = 32'h12345678; b0 = 32'h0;
    tick();
    start0 = 1'b0;
    $display("txn dut0 MTLO a=12345678 lo=%h busy=%b", lo0, busy0);
    n_checks++; if (lo0 !== 32'h12345678) begin n_fail++; $display("FAIL mtlo_lo got=%h exp=12345678", lo0); end
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy got=%b exp=0", busy0); end
    start0 = 1'b1; op0 = MD_MTHI; a0 = 32'hCAFEBABE;
    tick();
    start0 = 1'b0;
    $display("txn dut0 MTHI a=cafebabe hi=%h busy=%b", hi0, busy0);
    n_checks++; if (hi0 !== 32'hCAFEBABE) begin n_fail++; $display("FAIL mthi_hi got=%h exp=cafebabe", hi0); end
    n_checks++; if (lo0 !== 32'h12345678) begin n_fail++; $display("FAIL mthi_lo_kept got=%h exp=12345678", lo0); end
    run_op(0, MD_DIV, 32'd100, 32'd0, bc);
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL divzero_busy got=%0d exp=10", bc); end
    n_checks++; if (hi0 !== 32'hCAFEBABE) begin n_fail++; $display("FAIL divzero_hi got=%h exp=cafebabe", hi0); end
    n_checks++; if (lo0 !== 32'h12345678) begin n_fail++; $display("FAIL divzero_lo got=%h exp=12345678", lo0); end
    // Undefined op is a no-op.
    start0 = 1'b1; op0 = 3'd7; a0 = 32'h11111111;
    tick();
    start0 = 1'b0;
    $display("txn dut0 op=7 hi=%h lo=%h busy=%b", hi0, lo0, busy0);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL undef_busy got=%b exp=0", busy0); end
    n_checks++; if (hi0 !== 32'hCAFEBABE || lo0 !== 32'h12345678) begin
      n_fail++; $display("FAIL undef_hilo got=%h/%h exp=cafebabe/12345678", hi0, lo0);
    end
  endtask

  task automatic test_overflow();
    int bc;
    run_op(0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, bc);
    n_checks++; if (lo0 !== 32'h80000000) begin n_fail++; $display("FAIL ovf_lo got=%h exp=80000000", lo0); end
    n_checks++; if (hi0 !== 32'h0) begin n_fail++; $display("FAIL ovf_hi got=%h exp=00000000", hi0); end
    run_op(0, MD_DIVU, 32'h80000000, 32'hFFFFFFFF, bc);
    n_checks++; if (lo0 !== 32'h0 || hi0 !== 32'h80000000) begin
      n_fail++; $display("FAIL divu_big got=%h/%h exp=80000000/00000000", hi0, lo0);
    end
  endtask

  task automatic test_ignore_while_busy();
    // MULT 6*7; t = accept edge, bench now in cycle t+1.
    start0 = 1'b1; op0 = MD_MULT; a0 = 32'd6; b0 = 32'd7;
    tick();
    start0 = 1'b1; op0 = MD_MTHI; a0 = 32'hDEADBEEF;
    tick();
    start0 = 1'b1; op0 = MD_DIV; a0 = 32'd9; b0 = 32'd2;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    // Cycle t+5: last busy cycle; this start must be ignored.
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL ign_busy_last got=%b exp=1", busy0); end
    start0 = 1'b1; op0 = MD_MTLO; a0 = 32'h0BADF00D;
    tick();
    start0 = 1'b0;
    $display("txn dut0 MULT 6*7 with starts during busy hi=%h lo=%h busy=%b", hi0, lo0, busy0);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL ign_busy_fall got=%b exp=0", busy0); end
    n_checks++; if (lo0 !== 32'd42) begin n_fail++; $display("FAIL ign_lo got=%h exp=0000002a", lo0); end
    n_checks++; if (hi0 !== 32'd0) begin n_fail++; $display("FAIL ign_hi got=%h exp=00000000", hi0); end
    tick();
    n_checks++; if (busy0 !== 1'b0 || lo0 !== 32'd42) begin
      n_fail++; $display("FAIL ign_after got=busy %b lo %h exp=busy 0 lo 0000002a", busy0, lo0);
    end
  endtask

  task automatic test_reset_abort();
    start0 = 1'b1; op0 = MD_DIV; a0 = 32'd100; b0 = 32'd7;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    tick();
    // Cycle t+4: abort.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("txn dut0 DIV 100/7 aborted by reset hi=%h lo=%h busy=%b", hi0, lo0, busy0);
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy0); end
    n_checks++; if (hi0 !== 32'h0 || lo0 !== 32'h0) begin
      n_fail++; $display("FAIL abort_hilo got=%h/%h exp=00000000/00000000", hi0, lo0);
    end
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (busy0 !== 1'b0 || hi0 !== 32'h0 || lo0 !== 32'h0) begin
      n_fail++; $display("FAIL abort_late got=busy %b %h/%h exp=busy 0 00000000/00000000", busy0, hi0, lo0);
    end
  endtask

  task automatic test_short_latency();
    int bc;
    run_op(1, MD_MULT, 32'd6, 32'd7, bc);
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL p_mult_busy got=%0d exp=1", bc); end
    n_checks++; if (lo1 !== 32'd42 || hi1 !== 32'd0) begin
      n_fail++; $display("FAIL p_mult got=%h/%h exp=00000000/0000002a", hi1, lo1);
    end
    // Back-to-back: issued in the first idle cycle.
    run_op(1, MD_DIV, 32'hFFFFFFF9, 32'd2, bc);
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL p_div_busy got=%0d exp=3", bc); end
    n_checks++; if (lo1 !== 32'hFFFFFFFD || hi1 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL p_div got=%h/%h exp=ffffffff/fffffffd", hi1, lo1);
    end
    run_op(1, MD_DIVU, 32'd5, 32'd0, bc);
    n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL p_divz_busy got=%0d exp=3", bc); end
    n_checks++; if (lo1 !== 32'hFFFFFFFD || hi1 !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL p_divz got=%h/%h exp=ffffffff/fffffffd", hi1, lo1);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt_divzero();
    test_overflow();
    test_ignore_while_busy();
    test_reset_abort();
    test_short_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in the execute stage and executes mult, multu, div, divu, mthi and mtlo. Results land in internal HI/LO registers after a configurable latency. A busy flag lets the hazard unit stall mfhi/mflo and further md instructions until the operation completes.

## Interface
- WIDTH, 32: operand and HI/LO width; must be ≥ 2.
- MULT_LAT, 5: cycles busy is held for mult/multu; must be ≥ 1.
- DIV_LAT, 10: cycles busy is held for div/divu; must be ≥ 1.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid for one cycle (E-stage md instruction).
- op  in  3  operation code; encodings come from md_pkg.
- a  in  WIDTH  rs operand (forwarded value).
- b  in  WIDTH  rt operand (forwarded value).
- busy  out  1  a multi-cycle operation is in progress.
- hi  out  WIDTH  HI register value.
- lo  out  WIDTH  LO register value.

## Operation
- State machine has two states: IDLE and RUN.
- In IDLE, a start with op MULT/MULTU/DIV/DIVU is accepted:
  - The result is computed from a and b and captured into pending registers (pend_hi, pend_lo).
  - The counter is loaded with MULT_LAT or DIV_LAT.
  - The state moves to RUN.
- In IDLE, a start with MTHI writes hi←a, and a start with MTLO writes lo←a. Both take effect on that same edge, and busy stays 0.
- In RUN, the counter decrements every cycle. When it reaches 1, the next edge commits pend_hi/pend_lo to hi/lo and returns the state to IDLE.
- A start arriving while in RUN is ignored, including MTHI/MTLO. Stalling on start||busy is the hazard unit's responsibility.
- An undefined op code with start=1 is a no-op.
- Result rules:
  - MULT: signed 2·WIDTH product; hi = upper half, lo = lower half.
  - MULTU: the same, unsigned.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (b=0, DIV or DIVU): the operation still occupies DIV_LAT cycles, but hi/lo keep their previous values; nothing is committed.
  - Signed overflow (a = most negative, b = −1): lo = most negative, hi = 0.
- Reset: hi=0, lo=0, busy=0, state IDLE, counter 0, pending registers 0. A reset asserted during RUN aborts the operation, with no commit.

## Timing
- Start sampled on edge t. busy=1 during cycles t+1 … t+LAT. On edge t+LAT, hi/lo are updated and busy falls; new values are visible from cycle t+LAT+1.
- busy is a registered output. It is never combinationally asserted by start; the hazard unit ORs start itself.
- MTHI/MTLO latency is one edge: the value is visible in the cycle after start.
- A start in the same cycle as busy falling is ignored, because the state is still RUN. A start is accepted only in the first IDLE cycle or later.
- Back-to-back operations: the minimum accept spacing is LAT+1 cycles.
- The counter width is $clog2(max(MULT_LAT, DIV_LAT)+1).

## Structure
- md_pkg holds:
  - the op encodings: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5;
  - the state enum: IDLE, RUN.
- One combinational sub-module, md_arith, takes op, a and b and returns res_hi, res_lo and div_zero.
- md_unit holds the FSM, counter, pending registers and HI/LO.

## Test plan
- MULT with a=0xFFFFFFFD, b=5 → busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIV with a=0xFFFFFFF9 (−7), b=2 → busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=2 → lo=3, hi=1.
- MTLO with a=0x12345678, then MTHI with a=0xCAFEBABE; then DIV by b=0 → busy for 10 cycles, and hi/lo stay 0xCAFEBABE/0x12345678.
- DIV with a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start MULT, then assert MTHI and a DIV start during busy, and another start on the cycle busy falls → all ignored; only the MULT result is committed.
- Start DIV, assert reset at cycle 4 → hi=lo=0 and busy=0 the next cycle, no late commit. Also rerun with MULT_LAT=1, DIV_LAT=3 to confirm the parameters.
